heart_surprise_ctrl: RTL and testbench
======================================

HEART_SURPRISE_CTRL -- requirements
Module: heart_surprise_ctrl

Interface
REQ-001 SHALL have parameter SPAWN_DELAY_FRAMES, default 180: frames waited before each spawn.
REQ-002 SHALL have parameter SHOW_FRAMES, default 300: frames the heart is steadily visible.
REQ-003 SHALL have parameter BLINK_FRAMES, default 120: frames of blinking before timeout.
REQ-004 SHALL have parameter BLINK_PERIOD, default 8: frames per blink half-period.
REQ-005 SHALL have parameter INIT_LIVES, default 3, and MAX_LIVES, default 5.
REQ-006 SHALL have port clk  in  1  system clock; the block uses one clock only.
REQ-007 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port startOfFrame  in  1  one-cycle pulse per video frame.
REQ-009 SHALL have port enable  in  1  game running; when low, all frame counting freezes.
REQ-010 SHALL have port collision  in  1  player/heart overlap, level signal.
REQ-011 SHALL have port loseLife  in  1  one-cycle pulse that decrements lives.
REQ-012 SHALL have ports randX / randY  in  11 each  pseudo-random spawn coordinates.
REQ-013 SHALL have ports topLeftX / topLeftY  out  11 each  heart position, registered.
REQ-014 SHALL have port heartVisible  out  1  gates the heart bitmap's InsideRectangle.
REQ-015 SHALL have port lifeInc  out  1  one-cycle pulse on each collection.
REQ-016 SHALL have port lives  out  3  current life count.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT_SPAWN, SHOW, BLINK and COLLECTED.
REQ-018 IDLE SHALL go to WAIT_SPAWN on the first cycle with enable=1, clearing frameCnt.
REQ-019 frameCnt SHALL increment only on cycles where startOfFrame=1 and enable=1.
REQ-020 WAIT_SPAWN SHALL go to SHOW when frameCnt reaches SPAWN_DELAY_FRAMES-1 on a counted frame; on that cycle it SHALL clear frameCnt and latch the clamped position.
REQ-021 Position clamp SHALL be topLeftX=min(randX,607) and topLeftY=min(randY,447) (640x480 screen, 32x32 sprite).
REQ-022 SHOW SHALL go to BLINK after SHOW_FRAMES counted frames, clearing frameCnt.
REQ-023 BLINK SHALL go to WAIT_SPAWN after BLINK_FRAMES counted frames, with no life change.
REQ-024 heartVisible SHALL be 1 throughout SHOW and 0 in IDLE, WAIT_SPAWN and COLLECTED.
REQ-025 In BLINK, heartVisible SHALL equal NOT bit log2(BLINK_PERIOD) of frameCnt, so it starts visible; BLINK_PERIOD is a power of two.
REQ-026 collision=1 in SHOW or BLINK SHALL take the FSM to COLLECTED on the next edge and force heartVisible to 0; collision in any other state is ignored.
REQ-027 COLLECTED SHALL last exactly one cycle, assert lifeInc, then go to WAIT_SPAWN with frameCnt cleared.
REQ-028 A collision and a timeout on the same cycle SHALL resolve as a collection.
REQ-029 lives SHALL increment on lifeInc, saturating at MAX_LIVES; lifeInc still pulses when lives is saturated.
REQ-030 lives SHALL decrement on loseLife, saturating at 0.
REQ-031 lifeInc and loseLife on the same cycle SHALL leave lives unchanged.
REQ-032 enable=0 SHALL hold the state, frameCnt and outputs.
REQ-033 A collision already present in COLLECTED is ignored; collection is counted once per spawn.

Reset
REQ-034 reset SHALL set: state=IDLE, frameCnt=0, topLeftX=0, topLeftY=0, heartVisible=0, lifeInc=0, lives=INIT_LIVES.
REQ-035 reset SHALL override all inputs on the same edge, including reset asserted mid-SHOW or mid-COLLECTED; no lifeInc pulse is emitted afterwards.

Structure
REQ-036 The FSM state enum, SCREEN_W=640, SCREEN_H=480, SPRITE_SIZE=32 and the lives width SHALL live in the shared game package.
REQ-037 The lives saturating up/down counter SHALL be a sub-module named lives_counter; everything else stays in one module.

Verification (SPAWN=2, SHOW=3, BLINK=4, PERIOD=2)
REQ-038 Reset, enable=1, 9 frames with no collision -> heartVisible 0 for 2 frames, 1 for 3, then 1,1,0,0 during blink; state returns to WAIT_SPAWN; lives=3.
REQ-039 randX=700, randY=100 at spawn -> topLeftX=607, topLeftY=100.
REQ-040 collision in the 2nd SHOW frame -> one lifeInc pulse, lives=4, heartVisible=0 the next cycle; holding collision high for 10 cycles gives no second pulse.
REQ-041 Lives at 5, then a collection -> lifeInc pulses and lives stays 5; 6 loseLife pulses -> lives=0.
REQ-042 Collection with loseLife on the same cycle as lifeInc -> lives unchanged.
REQ-043 enable=0 mid-SHOW for 5 frames, then enable=1 -> SHOW resumes with its remaining frame count intact; reset mid-BLINK -> IDLE with lives=3.

Source files
------------

// File: rtl/heart_surprise_ctrl_pkg.sv
// Shared game package: screen geometry, lives width, heart FSM states and
// the spawn-position clamp helper.
package heart_surprise_ctrl_pkg;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int SPRITE_SIZE = 32;
  localparam int LIVES_W     = 3;
  localparam int COORD_W     = 11;
  localparam int CNT_W       = 16;

  // Largest top-left coordinate that keeps the whole sprite on screen.
  localparam logic [COORD_W-1:0] MAX_X = COORD_W'(SCREEN_W - SPRITE_SIZE - 1);
  localparam logic [COORD_W-1:0] MAX_Y = COORD_W'(SCREEN_H - SPRITE_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_SPAWN = 3'd1,
    SHOW       = 3'd2,
    BLINK      = 3'd3,
    COLLECTED  = 3'd4
  } heart_state_e;

  function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] v,
                                                     input logic [COORD_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/heart_surprise_ctrl_lives_counter.sv
// Saturating up/down life counter. Simultaneous inc and dec cancel out.
module lives_counter
  import heart_surprise_ctrl_pkg::*;
#(
  parameter int INIT_LIVES = 3,
  parameter int MAX_LIVES  = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc_i,
  input  logic               dec_i,
  output logic [LIVES_W-1:0] lives_o
);

  localparam logic [LIVES_W-1:0] INIT_L = LIVES_W'(INIT_LIVES);
  localparam logic [LIVES_W-1:0] MAX_L  = LIVES_W'(MAX_LIVES);

  logic [LIVES_W-1:0] lives_q, lives_d;

  // Next count: saturate at MAX_L going up and at zero going down.
  always_comb begin
    lives_d = lives_q;
    if (inc_i && !dec_i) begin
      if (lives_q < MAX_L) lives_d = lives_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      if (lives_q != '0) lives_d = lives_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) lives_q <= INIT_L;
    else       lives_q <= lives_d;
  end

  assign lives_o = lives_q;

endmodule

// File: rtl/heart_surprise_ctrl.sv
// Bonus-heart controller: waits, spawns a heart at a clamped random spot,
// shows it steadily, blinks it, then times out unless the player collects it.
module heart_surprise_ctrl
  import heart_surprise_ctrl_pkg::*;
#(
  parameter int SPAWN_DELAY_FRAMES = 180,
  parameter int SHOW_FRAMES        = 300,
  parameter int BLINK_FRAMES       = 120,
  parameter int BLINK_PERIOD       = 8,
  parameter int INIT_LIVES         = 3,
  parameter int MAX_LIVES          = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               enable,
  input  logic               collision,
  input  logic               loseLife,
  input  logic [COORD_W-1:0] randX,
  input  logic [COORD_W-1:0] randY,
  output logic [COORD_W-1:0] topLeftX,
  output logic [COORD_W-1:0] topLeftY,
  output logic               heartVisible,
  output logic               lifeInc,
  output logic [LIVES_W-1:0] lives
);

  localparam logic [CNT_W-1:0] SPAWN_LAST = CNT_W'(SPAWN_DELAY_FRAMES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
  // Frame-count bit that toggles every BLINK_PERIOD frames.
  localparam int BLINK_BIT = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 0;

  heart_state_e       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               vis_q, vis_d;
  logic               inc_q, inc_d;
  logic               frame_tick;

  // Frames only count while the game is running.
  assign frame_tick = startOfFrame & enable;

  // Next state, frame counter, spawn position and registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = WAIT_SPAWN;
          cnt_d   = '0;
        end
      end
      WAIT_SPAWN: begin
        if (frame_tick) begin
          if (cnt_q == SPAWN_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
            x_d     = clamp_coord(randX, MAX_X);
            y_d     = clamp_coord(randY, MAX_Y);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      SHOW: begin
        // Collection wins over a timeout landing on the same cycle.
        if (enable && collision) begin
          state_d = COLLECTED;
        end else if (frame_tick) begin
          if (cnt_q == SHOW_LAST) begin
            state_d = BLINK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      BLINK: begin
        if (enable && collision) begin
          state_d = COLLECTED;
        end else if (frame_tick) begin
          if (cnt_q == BLINK_LAST) begin
            state_d = WAIT_SPAWN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      COLLECTED: begin
        // Single-cycle state; a lingering collision cannot re-trigger it.
        state_d = WAIT_SPAWN;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs follow the next state so they line up with state_q.
    case (state_d)
      SHOW:    vis_d = 1'b1;
      BLINK:   vis_d = ~cnt_d[BLINK_BIT];
      default: vis_d = 1'b0;
    endcase
    inc_d = (state_d == COLLECTED);
  end

  // State and output registers; reset overrides every input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      vis_q   <= 1'b0;
      inc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vis_q   <= vis_d;
      inc_q   <= inc_d;
    end
  end

  lives_counter #(
    .INIT_LIVES(INIT_LIVES),
    .MAX_LIVES (MAX_LIVES)
  ) u_lives (
    .clk    (clk),
    .reset  (reset),
    .inc_i  (inc_q),
    .dec_i  (loseLife),
    .lives_o(lives)
  );

  assign topLeftX     = x_q;
  assign topLeftY     = y_q;
  assign heartVisible = vis_q;
  assign lifeInc      = inc_q;

endmodule

// File: tb/tb_heart_surprise_ctrl.sv
// Scoreboard bench for heart_surprise_ctrl with short frame parameters.
module tb_heart_surprise_ctrl;
  import heart_surprise_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        startOfFrame = 1'b0;
  logic        enable = 1'b0;
  logic        collision = 1'b0;
  logic        loseLife = 1'b0;
  logic [10:0] randX = '0;
  logic [10:0] randY = '0;
  logic [10:0] topLeftX, topLeftY;
  logic        heartVisible, lifeInc;
  logic [2:0]  lives;

  int total = 0;
  int bad   = 0;

  typedef enum int {S_VIS, S_LIVES, S_INC, S_X, S_Y, S_STATE} sig_e;
  typedef struct {
    string       tag;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  heart_surprise_ctrl #(
    .SPAWN_DELAY_FRAMES(2),
    .SHOW_FRAMES       (3),
    .BLINK_FRAMES      (4),
    .BLINK_PERIOD      (2),
    .INIT_LIVES        (3),
    .MAX_LIVES         (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .startOfFrame(startOfFrame),
    .enable      (enable),
    .collision   (collision),
    .loseLife    (loseLife),
    .randX       (randX),
    .randY       (randY),
    .topLeftX    (topLeftX),
    .topLeftY    (topLeftY),
    .heartVisible(heartVisible),
    .lifeInc     (lifeInc),
    .lives       (lives)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input sig_e s);
    case (s)
      S_VIS:   return {31'd0, heartVisible};
      S_LIVES: return {29'd0, lives};
      S_INC:   return {31'd0, lifeInc};
      S_X:     return {21'd0, topLeftX};
      S_Y:     return {21'd0, topLeftY};
      default: return {29'd0, dut.state_q};
    endcase
  endfunction

  task automatic push(input string tag, input sig_e s, input int v);
    exp_t e;
    e.tag = tag; e.sig = s; e.val = 32'(v);
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, observe(e.sig), e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One-cycle frame pulse; returns 1 time unit after the counting edge.
  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  // From WAIT_SPAWN with a cleared count: spawn, collide in the 2nd SHOW frame.
  task automatic collect(input logic lose_same);
    frame(); tick();
    frame(); tick();
    frame(); tick();
    collision = 1'b1;
    tick();
    push("collect_inc", S_INC, 1);
    push("collect_vis", S_VIS, 0);
    drain();
    collision = 1'b0;
    loseLife  = lose_same;
    tick();
    loseLife  = 1'b0;
  endtask

  initial begin : main
    int exp_vis[9] = '{0, 1, 1, 1, 1, 1, 0, 0, 0};
    int pulses;

    // Reset state
    tick(); tick();
    reset = 1'b0;
    push("rst_state", S_STATE, IDLE);
    push("rst_vis", S_VIS, 0);
    push("rst_inc", S_INC, 0);
    push("rst_lives", S_LIVES, 3);
    push("rst_x", S_X, 0);
    push("rst_y", S_Y, 0);
    drain();

    // Full spawn/show/blink/timeout cycle with X clamp
    randX = 11'd700; randY = 11'd100;
    enable = 1'b1;
    tick();
    push("idle_to_wait", S_STATE, WAIT_SPAWN);
    drain();
    for (int i = 0; i < 9; i++) begin
      push($sformatf("vis_f%0d", i + 1), S_VIS, exp_vis[i]);
      if (i == 1) begin
        push("clamp_x", S_X, 607);
        push("clamp_y", S_Y, 100);
      end
      frame();
      drain();
      tick();
    end
    push("timeout_state", S_STATE, WAIT_SPAWN);
    push("timeout_lives", S_LIVES, 3);
    drain();

    // Collection with collision held high for 10 cycles
    frame(); tick();
    frame(); tick();
    frame(); tick();
    collision = 1'b1;
    tick();
    push("c1_inc", S_INC, 1);
    push("c1_vis", S_VIS, 0);
    drain();
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (lifeInc) pulses++;
    end
    collision = 1'b0;
    chk("c1_no_repeat", 32'(pulses), 32'd0);
    push("c1_lives", S_LIVES, 4);
    drain();

    // Saturation at MAX_LIVES, then down to zero
    collect(1'b0);
    push("lives_to5", S_LIVES, 5);
    drain();
    collect(1'b0);
    push("sat_lives", S_LIVES, 5);
    drain();
    for (int i = 0; i < 6; i++) begin
      loseLife = 1'b1; tick(); loseLife = 1'b0; tick();
    end
    push("lives_zero", S_LIVES, 0);
    drain();

    // Increment and decrement on the same cycle
    collect(1'b0);
    push("lives_one", S_LIVES, 1);
    drain();
    collect(1'b1);
    push("inc_dec_same", S_LIVES, 1);
    drain();

    // Freeze mid-SHOW, then resume with the remaining count
    frame(); tick();
    frame(); tick();
    frame(); tick();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      frame(); tick();
    end
    push("frz_state", S_STATE, SHOW);
    push("frz_vis", S_VIS, 1);
    drain();
    enable = 1'b1;
    frame();
    push("resume_show", S_STATE, SHOW);
    drain();
    tick();
    frame();
    push("resume_blink", S_STATE, BLINK);
    push("resume_vis", S_VIS, 1);
    drain();
    tick();
    frame(); tick();

    // Reset mid-BLINK
    reset = 1'b1; tick(); reset = 1'b0;
    push("rb_state", S_STATE, IDLE);
    push("rb_lives", S_LIVES, 3);
    push("rb_vis", S_VIS, 0);
    drain();

    // Reset mid-COLLECTED: no pulse and no increment afterwards
    tick();
    frame(); tick();
    frame(); tick();
    frame(); tick();
    collision = 1'b1;
    tick();
    reset = 1'b1; collision = 1'b0;
    tick();
    reset = 1'b0;
    push("rc_state", S_STATE, IDLE);
    push("rc_inc", S_INC, 0);
    drain();
    tick(); tick();
    push("rc_inc_after", S_INC, 0);
    push("rc_lives", S_LIVES, 3);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
